// File: rtl/seq_initiator.sv
// seq_initiator: two-step strobe handshake initiator running bursts of sequences against a peer detector
module seq_initiator #(
  parameter int TIMEOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_count,
  input  logic       i_peer_a,
  input  logic       i_peer_b,
  output logic       o_sig_1,
  output logic       o_sig_2,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_seq_cnt
);
  typedef enum logic [2:0] {IDLE, ARM, FIRE, GAP, DONE} state_t;
  localparam logic [3:0] TMAX = 4'(TIMEOUT - 1);
  state_t     r_state;
  logic [3:0] r_remaining;
  logic [3:0] r_timer;
  logic [3:0] r_seq_cnt;
  logic       r_err;
  // burst sequencing: handshake steps, retry timer, completion count and sticky abort flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_timer     <= '0;
      r_seq_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state     <= (i_count != 4'd0) ? ARM : DONE;
          r_remaining <= i_count;
          r_timer     <= '0;
          r_seq_cnt   <= '0;
          r_err       <= 1'b0;
        end
        ARM: if (i_peer_a) r_state <= FIRE;
        else if (r_timer == TMAX) begin
          r_state <= DONE;
          r_err   <= 1'b1;
        end else r_timer <= r_timer + 4'd1;
        FIRE: if (i_peer_b) begin
          r_state     <= GAP;
          r_seq_cnt   <= r_seq_cnt + 4'd1;
          r_remaining <= r_remaining - 4'd1;
        end else begin
          r_state <= DONE;
          r_err   <= 1'b1;
        end
        GAP: begin
          r_state <= (r_remaining != 4'd0) ? ARM : DONE;
          r_timer <= '0;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_sig_1   = (r_state == ARM);
  assign o_sig_2   = (r_state == FIRE);
  assign o_busy    = (r_state == ARM) || (r_state == FIRE) || (r_state == GAP) || (r_state == DONE);
  assign o_done    = (r_state == DONE);
  assign o_err     = r_err;
  assign o_seq_cnt = r_seq_cnt;
endmodule

// File: tb/tb_seq_initiator.sv
// tb_seq_initiator: directed scoreboard bench for seq_initiator with a switchable compliant peer
module tb_seq_initiator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count = '0;
  logic       en_a = 1'b1;
  logic       en_b = 1'b1;
  logic       peer_a, peer_b;
  logic       sig_1, sig_2, busy, done, err;
  logic [3:0] seq_cnt;
  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  seq_initiator #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_count(count),
    .i_peer_a(peer_a), .i_peer_b(peer_b),
    .o_sig_1(sig_1), .o_sig_2(sig_2), .o_busy(busy), .o_done(done),
    .o_err(err), .o_seq_cnt(seq_cnt)
  );
  // peer accepts step 1 while idle and reports armed during step 2, unless disabled
  assign peer_a = en_a & sig_1;
  assign peer_b = en_b & sig_2;
  always #5 clk = ~clk;
  task automatic push(input logic s1, input logic s2, input logic b, input logic d, input logic e, input logic [3:0] c);
    q.push_back({s1, s2, b, d, e, c});
  endtask
  task automatic idle(input logic e, input logic [3:0] c); push(0, 0, 0, 0, e, c); endtask
  task automatic arm(input logic [3:0] c);                 push(1, 0, 1, 0, 0, c); endtask
  task automatic fire(input logic [3:0] c);                push(0, 1, 1, 0, 0, c); endtask
  task automatic gap(input logic [3:0] c);                 push(0, 0, 1, 0, 0, c); endtask
  task automatic fin(input logic e, input logic [3:0] c);  push(0, 0, 1, 1, e, c); endtask
  task automatic check(input string tag);
    exp_t exp_v, obs;
    obs = {sig_1, sig_2, busy, done, err, seq_cnt};
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, observed s1/s2/busy/done/err/cnt=%b", tag, obs);
    end else begin
      exp_v = q.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed s1/s2/busy/done/err/cnt=%b expected %b", tag, obs, exp_v);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag);
    while (q.size() > 0) begin
      check(tag);
      step();
    end
  endtask
  task automatic go(input logic [3:0] c);
    start = 1'b1;
    count = c;
    step();
    start = 1'b0;
  endtask
  initial begin
    #12;
    idle(0, 0);
    check("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    step();
    idle(0, 0); idle(0, 0);
    drain("post_reset_idle");
    go(3);
    for (int k = 0; k < 3; k++) begin
      arm(4'(k)); fire(4'(k)); gap(4'(k + 1));
    end
    fin(0, 3); idle(0, 3); idle(0, 3);
    drain("burst3");
    go(0);
    fin(0, 0); idle(0, 0);
    drain("count0");
    en_a = 1'b0;
    go(2);
    repeat (8) arm(0);
    fin(1, 0); idle(1, 0); idle(1, 0);
    drain("timeout");
    en_a = 1'b1;
    go(2);
    arm(0); fire(0); gap(1);
    drain("abort_pre");
    en_b = 1'b0;
    arm(1); fire(1); fin(1, 1); idle(1, 1);
    drain("abort_fire");
    en_b = 1'b1;
    go(1);
    arm(0); fire(0); gap(1); fin(0, 1); idle(0, 1);
    drain("recover");
    go(5);
    arm(0);
    check("b5_arm1");
    step();
    start = 1'b1;
    count = 4'd1;
    fire(0);
    check("busy_start");
    step();
    start = 1'b0;
    gap(1); arm(1); fire(1); gap(2);
    drain("b5_mid");
    arm(2);
    check("third_arm");
    #2 rst_n = 1'b0;
    #1;
    idle(0, 0);
    check("rst_async");
    step();
    idle(0, 0); idle(0, 0);
    drain("rst_held");
    @(negedge clk) rst_n = 1'b1;
    step();
    idle(0, 0); idle(0, 0); idle(0, 0);
    drain("wait_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_initiator.md
SEQ_INITIATOR -- requirements
Module: seq_initiator

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum consecutive ARM cycles without peer_a before abort (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately regardless of clk.
REQ-004 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 count  input  4  number of sequences in the burst; sampled with start.
REQ-006 peer_a  input  1  peer detector output, high when peer is in its idle state and sig_1 or sig_2 is high.
REQ-007 peer_b  input  1  peer detector output, high when peer is in its armed state.
REQ-008 sig_1  output  1  first-step strobe to peer.
REQ-009 sig_2  output  1  second-step strobe to peer.
REQ-010 busy  output  1  high while a burst is in progress (any state other than IDLE).
REQ-011 done  output  1  one-cycle pulse at burst end, on completion or abort.
REQ-012 err  output  1  sticky abort flag.
REQ-013 seq_cnt  output  4  sequences completed in the current or last burst.

Function
REQ-014 States: IDLE, ARM, FIRE, GAP, DONE; held in a state register.
REQ-015 sig_1=1 only in ARM, sig_2=1 only in FIRE, busy=1 in ARM/FIRE/GAP/DONE, done=1 only in DONE; all are decoded from the state register only, with no combinational path from any input.
REQ-016 IDLE: start=1 and count!=0 -> ARM; latch remaining=count; clear seq_cnt, err, and retry timer.
REQ-017 IDLE: start=1 and count=0 -> DONE; seq_cnt=0, err=0, no strobe issued.
REQ-018 ARM: peer_a=1 -> FIRE next cycle, because the peer has accepted step 1.
REQ-019 ARM: peer_a=0 -> stay ARM and increment timer; when timer reaches TIMEOUT-1 with peer_a=0, abort: go to DONE and set err=1.
REQ-020 FIRE: peer_b=1 -> GAP, increment seq_cnt, decrement remaining.
REQ-021 FIRE: peer_b=0 -> protocol abort: go to DONE, set err=1, seq_cnt unchanged.
REQ-022 GAP: both strobes low for one cycle, which lets the peer return to idle; remaining!=0 -> ARM with timer cleared; remaining=0 -> DONE.
REQ-023 DONE: lasts exactly one cycle, then IDLE.
REQ-024 Minimum sequence latency is 3 cycles (ARM, FIRE, GAP); an N-sequence burst with immediate peer acceptance gives done at cycle 3N+1 after start is sampled.
REQ-025 start while busy=1 is ignored; count is not re-sampled.
REQ-026 err holds until the next accepted start; seq_cnt holds after DONE until the next accepted start.
REQ-027 seq_cnt never wraps, because count<=15.
REQ-028 Any state value outside REQ-014 -> IDLE on the next clock.

Reset
REQ-029 rst=0 -> state=IDLE, sig_1=0, sig_2=0, busy=0, done=0, err=0, seq_cnt=0, remaining=0, timer=0, all asynchronously.
REQ-030 Reset mid-burst drops strobes immediately with no done pulse; after rst releases, the block waits in IDLE for a new start.

Verification
REQ-031 start, count=3, peer model compliant -> sig_1 at cycles 1/4/7, sig_2 at cycles 2/5/8, done at cycle 10, seq_cnt=3, err=0.
REQ-032 start, count=0 -> done at cycle 1, sig_1/sig_2 never high, seq_cnt=0.
REQ-033 start, count=2, peer_a held 0, TIMEOUT=8 -> sig_1 high for 8 cycles, then done with err=1, seq_cnt=0.
REQ-034 start, count=2, peer_b forced 0 during the second FIRE -> done 1 cycle later, err=1, seq_cnt=1.
REQ-035 start, count=5; start pulsed again during the burst; rst=0 asserted in the third ARM -> second start ignored; on rst all outputs are 0 immediately, with no done pulse.
REQ-036 After an abort, a new start with count=1 and a compliant peer -> err clears at the accepted start; done at cycle 4 with seq_cnt=1.
